// File: rtl/dm_responder.sv
// dm_responder -- data-memory responder for a CPU load/store port.
//
// Accepts one load or store request at a time and answers exactly LATENCY
// cycles after acceptance with a one-cycle rsp_valid pulse. The memory is a
// DEPTH_WORDS x 32 array addressed by word index. Upper address bits alias.
// Stores use an unshifted byte mask. Loads are sign- or zero-extended by func3.
//
// Parameters
//   DEPTH_WORDS  memory size in 32-bit words (power of two), default 1024
//   LATENCY      cycles from acceptance to response, 1..8, default 2
//
// Ports
//   clk, rst_n   clock; asynchronous active-low reset
//   req_valid    request present             req_ready  idle, can accept
//   addr         byte address                w_en       store byte mask (0 = load)
//   func3        load type                   wdata      store data, LSB-justified
//   rsp_valid    completion pulse            rdata      load result (0 for stores)
//   busy         stall request, high when not idle
//   err          misaligned access, valid with rsp_valid
//
// Optional feature: define DM_MISALIGN_CHECK_EN to flag misaligned halfword
// and word accesses. A flagged access is suppressed and returns err=1.
// Without the macro, err is tied low. Word accesses then ignore addr[1:0],
// and halfword accesses ignore addr[0].
module dm_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] addr,
    input  logic [3:0]  w_en,
    input  logic [2:0]  func3,
    input  logic [31:0] wdata,
    output logic        rsp_valid,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    typedef struct packed {
        logic [AW+1:0] addr;
        logic [3:0]    wen;
        logic [2:0]    f3;
        logic [31:0]   wd;
    } req_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    req_t        r_req;
    logic [31:0] r_mem [DEPTH_WORDS];

    req_t        w_in, w_cur;
    logic        w_accept, w_go_resp, w_is_store, w_word, w_half, w_bad, w_wr_en;
    logic [1:0]  w_off;
    logic [AW-1:0] w_idx;
    logic [3:0]  w_mask;
    logic [31:0] w_wd_sh, w_shr, w_load, w_rdata_nxt;
    logic        w_unused_addr;

    assign w_unused_addr = &{1'b0, addr[31:AW+2]};

    assign w_in     = '{addr: addr[AW+1:0], wen: w_en, f3: func3, wd: wdata};
    // With LATENCY=1 the response is produced on the acceptance edge itself,
    // so the live inputs are decoded instead of the latched copy.
    assign w_cur    = (r_state == S_IDLE) ? w_in : r_req;
    assign w_accept = req_valid && (r_state == S_IDLE);
    assign w_go_resp = (w_accept && (LATENCY == 1)) ||
                       ((r_state == S_WAIT) && (r_cnt == 4'd2));

    // Access size: stores by mask, loads by func3 (x1x is word, covering 011/110/111).
    assign w_is_store = |w_cur.wen;
    assign w_word = w_is_store ? (w_cur.wen == 4'b1111) : w_cur.f3[1];
    assign w_half = w_is_store ? (w_cur.wen == 4'b0011) : (w_cur.f3[1:0] == 2'b01);

`ifdef DM_MISALIGN_CHECK_EN
    assign w_bad = (w_half && w_cur.addr[0]) || (w_word && (w_cur.addr[1:0] != 2'b00));
`else
    assign w_bad = 1'b0;
`endif

    // Alignment-forced byte offset; misaligned accesses are suppressed anyway when checked.
    assign w_off  = w_word ? 2'b00 : (w_half ? {w_cur.addr[1], 1'b0} : w_cur.addr[1:0]);
    assign w_idx  = w_cur.addr[AW+1:2];
    assign w_mask = w_cur.wen << w_off;          // bits past byte 3 fall off
    assign w_wd_sh = w_cur.wd << {w_off, 3'b000};
    assign w_shr   = r_mem[w_idx] >> {w_off, 3'b000};

    always_comb begin
        w_load = w_shr;
        if (!w_cur.f3[1]) begin
            if (!w_cur.f3[0]) w_load = {{24{~w_cur.f3[2] & w_shr[7]}},  w_shr[7:0]};
            else              w_load = {{16{~w_cur.f3[2] & w_shr[15]}}, w_shr[15:0]};
        end
    end

    assign w_rdata_nxt = (w_is_store || w_bad) ? 32'd0 : w_load;
    assign w_wr_en     = w_go_resp && w_is_store && !w_bad;

    // Memory has no reset; rst_n only blocks a commit while reset is held.
    always_ff @(posedge clk) begin
        if (w_wr_en && rst_n) begin
            for (int b = 0; b < 4; b++)
                if (w_mask[b]) r_mem[w_idx][8*b +: 8] <= w_wd_sh[8*b +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_req     <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            rdata     <= 32'd0;
`ifdef DM_MISALIGN_CHECK_EN
            err       <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_req     <= w_in;
                    r_cnt     <= 4'(LATENCY);
                    r_state   <= S_WAIT;
                    req_ready <= 1'b0;
                    busy      <= 1'b1;
                end
                S_WAIT: r_cnt <= r_cnt - 4'd1;
                S_RESP: begin
                    r_state   <= S_IDLE;
                    r_cnt     <= 4'd0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
            // Entering RESP overrides the per-state next state above.
            if (w_go_resp) begin
                r_state   <= S_RESP;
                rsp_valid <= 1'b1;
                rdata     <= w_rdata_nxt;
`ifdef DM_MISALIGN_CHECK_EN
                err       <= w_bad;
`endif
            end
        end
    end

`ifndef DM_MISALIGN_CHECK_EN
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dm_responder.sv
module tb_dm_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0, vld1 = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  w_en = '0;
    logic [2:0]  func3 = '0;
    logic        req_ready, rsp_valid, busy, err;
    logic [31:0] rdata;
    logic        rdy1, rsp1, busy1, err1_unused;
    logic [31:0] rd1_unused;

`ifdef DM_MISALIGN_CHECK_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    dm_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .addr(addr), .w_en(w_en), .func3(func3), .wdata(wdata),
        .rsp_valid(rsp_valid), .rdata(rdata), .busy(busy), .err(err));

    dm_responder #(.DEPTH_WORDS(16), .LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(vld1), .req_ready(rdy1),
        .addr(addr), .w_en(w_en), .func3(func3), .wdata(wdata),
        .rsp_valid(rsp1), .rdata(rd1_unused), .busy(busy1), .err(err1_unused));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk = 0, n_fail = 0, last_busy = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    typedef struct { logic [31:0] rd; logic er; int acc; string nm; } exp_t;
    exp_t sbq[$];
    exp_t e;

    // Monitor: each response pops the oldest expectation. The response is
    // sampled by the rising edge that follows this falling edge.
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (sbq.size() == 0) chk("unexpected_rsp", sbq.size(), 1);
            else begin
                e = sbq.pop_front();
                chk({e.nm, "_rdata"}, rdata, e.rd);
                chk({e.nm, "_err"}, {31'd0, err}, {31'd0, e.er});
                chk({e.nm, "_latency"}, cyc + 1 - e.acc, 2);
            end
        end
    end

    task automatic do_req(input string nm, input logic [31:0] a, input logic [3:0] we,
                          input logic [2:0] f3, input logic [31:0] wd,
                          input logic [31:0] er, input logic ee);
        int n;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        if (!req_ready) begin chk({nm, "_ready_timeout"}, {31'd0, req_ready}, 1); return; end
        addr = a; w_en = we; func3 = f3; wdata = wd; req_valid = 1'b1;
        sbq.push_back('{er, ee, cyc + 1, nm});
        @(negedge clk);
        req_valid = 1'b0;
        n = 0; last_busy = 0;
        while (busy && n < 50) begin last_busy++; @(negedge clk); n++; end
        if (busy) chk({nm, "_busy_timeout"}, {31'd0, busy}, 0);
    endtask

    initial begin
        int last_acc, nacc;
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_err", {31'd0, err}, 0);
        @(negedge clk) rst_n = 1'b1;

        // Throughput on the LATENCY=3 instance with req_valid held high.
        @(negedge clk);
        addr = 32'h0; w_en = 4'h0; func3 = 3'b010; vld1 = 1'b1;
        last_acc = -100; nacc = 0;
        repeat (20) begin
            chk("l3_ready_vs_busy", {31'd0, rdy1}, {31'd0, ~busy1});
            if (rsp1) chk("l3_latency", cyc + 1 - last_acc, 3);
            if (rdy1) begin
                if (nacc > 0) chk("l3_accept_spacing", cyc + 1 - last_acc, 4);
                last_acc = cyc + 1; nacc++;
            end
            @(negedge clk);
        end
        vld1 = 1'b0;
        chk("l3_accept_count", nacc, 5);

        // Directed sequence on the LATENCY=2 instance.
        do_req("sw10",   32'h10, 4'b1111, 3'b010, 32'hDEADBEEF, 32'h0, 1'b0);
        chk("sw10_busy_cycles", last_busy, 2);
        do_req("lw10",   32'h10, 4'b0000, 3'b010, 32'h0, 32'hDEADBEEF, 1'b0);
        do_req("sb13",   32'h13, 4'b0001, 3'b000, 32'h000000AA, 32'h0, 1'b0);
        do_req("lw10b",  32'h10, 4'b0000, 3'b010, 32'h0, 32'hAAADBEEF, 1'b0);
        do_req("lb13",   32'h13, 4'b0000, 3'b000, 32'h0, 32'hFFFFFFAA, 1'b0);
        do_req("lbu13",  32'h13, 4'b0000, 3'b100, 32'h0, 32'h000000AA, 1'b0);
        do_req("sw20",   32'h20, 4'b1111, 3'b010, 32'h80017FFF, 32'h0, 1'b0);
        do_req("sh22",   32'h22, 4'b0011, 3'b001, 32'h00001234, 32'h0, 1'b0);
        do_req("lw20",   32'h20, 4'b0000, 3'b010, 32'h0, 32'h12347FFF, 1'b0);
        do_req("lh20",   32'h20, 4'b0000, 3'b001, 32'h0, 32'h00007FFF, 1'b0);
        do_req("lhu22",  32'h22, 4'b0000, 3'b101, 32'h0, 32'h00001234, 1'b0);
        do_req("lb20",   32'h20, 4'b0000, 3'b000, 32'h0, 32'hFFFFFFFF, 1'b0);
        do_req("lbu21",  32'h21, 4'b0000, 3'b100, 32'h0, 32'h0000007F, 1'b0);
        do_req("f3_011", 32'h20, 4'b0000, 3'b011, 32'h0, 32'h12347FFF, 1'b0);
        do_req("f3_111", 32'h20, 4'b0000, 3'b111, 32'h0, 32'h12347FFF, 1'b0);
        // Higher address bits alias onto the same word.
        do_req("alias1", 32'h00001010, 4'b0000, 3'b010, 32'h0, 32'hAAADBEEF, 1'b0);
        do_req("alias2", 32'h80000010, 4'b0000, 3'b010, 32'h0, 32'hAAADBEEF, 1'b0);
        // Misaligned accesses.
        do_req("lh21",   32'h21, 4'b0000, 3'b001, 32'h0, MIS ? 32'h0 : 32'h00007FFF, MIS);
        do_req("lw22",   32'h22, 4'b0000, 3'b010, 32'h0, MIS ? 32'h0 : 32'h12347FFF, MIS);
        do_req("sw11",   32'h11, 4'b1111, 3'b010, 32'h11223344, 32'h0, MIS);
        do_req("lw10c",  32'h10, 4'b0000, 3'b010, 32'h0, MIS ? 32'hAAADBEEF : 32'h11223344, 1'b0);

        // Reset in WAIT abandons the store.
        do_req("sw30",   32'h30, 4'b1111, 3'b010, 32'h01020304, 32'h0, 1'b0);
        do_req("lw30",   32'h30, 4'b0000, 3'b010, 32'h0, 32'h01020304, 1'b0);
        @(negedge clk);
        addr = 32'h30; w_en = 4'b1111; func3 = 3'b010; wdata = 32'hFFFFFFFF; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("abort_accepted_busy", {31'd0, busy}, 1);
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("abort_ready", {31'd0, req_ready}, 1);
        chk("abort_rsp_valid", {31'd0, rsp_valid}, 0);
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_rdata", rdata, 0);
        chk("abort_err", {31'd0, err}, 0);
        @(negedge clk) rst_n = 1'b1;
        w_en = 4'b0000;
        do_req("lw30b",  32'h30, 4'b0000, 3'b010, 32'h0, 32'h01020304, 1'b0);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end
endmodule
